// File: rtl/split_bus_arbiter_if.sv
// Shared bus bundle between two masters, three slaves and the arbiter.
// The arbiter connects through the slave modport; the master modport drives it.
interface split_bus_arbiter_if;
  logic        HREQ_1;
  logic        HREQ_2;
  logic        HLOCK_1;
  logic        HLOCK_2;
  logic [15:0] HADDR_1;
  logic [15:0] HADDR_2;
  logic [31:0] HWDATA_1;
  logic [31:0] HWDATA_2;
  logic [31:0] HRDATA_1;
  logic [31:0] HRDATA_2;
  logic [31:0] HRDATA_3;
  logic [1:0]  HRESP_1;
  logic [1:0]  HRESP_2;
  logic [1:0]  HRESP_3;
  logic        HREADY;
  logic [1:0]  HSPLIT;
  logic        HGRANT_1;
  logic        HGRANT_2;
  logic [1:0]  HMAS;
  logic        MLOCK;
  logic        SEL_1;
  logic        SEL_2;
  logic        SEL_3;
  logic [15:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;

  modport slave (
    input  HREQ_1, HREQ_2, HLOCK_1, HLOCK_2,
    input  HADDR_1, HADDR_2, HWDATA_1, HWDATA_2,
    input  HRDATA_1, HRDATA_2, HRDATA_3,
    input  HRESP_1, HRESP_2, HRESP_3,
    input  HREADY, HSPLIT,
    output HGRANT_1, HGRANT_2, HMAS, MLOCK,
    output SEL_1, SEL_2, SEL_3,
    output HADDR, HWDATA, HRDATA, HRESP
  );

  modport master (
    output HREQ_1, HREQ_2, HLOCK_1, HLOCK_2,
    output HADDR_1, HADDR_2, HWDATA_1, HWDATA_2,
    output HRDATA_1, HRDATA_2, HRDATA_3,
    output HRESP_1, HRESP_2, HRESP_3,
    output HREADY, HSPLIT,
    input  HGRANT_1, HGRANT_2, HMAS, MLOCK,
    input  SEL_1, SEL_2, SEL_3,
    input  HADDR, HWDATA, HRDATA, HRESP
  );
endinterface

// File: rtl/split_bus_arbiter.sv
// Two-master round-robin bus arbiter with lock, hold limit and split parking.
// Muxes the owner's address phase and routes the registered data phase.
module split_bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int SLV_LSB  = 12
) (
  input logic               CLK,
  input logic               RST,
  split_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M1 = 2'd1,
    OWN_M2 = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t      state;
  state_t      win;
  logic        mlock;
  logic        last_m2;
  logic [1:0]  mask;
  logic [7:0]  hold;
  logic [1:0]  dp_slv;
  logic [1:0]  dp_mas;
  logic        dp_err;

  logic [1:0]  req;
  logic [1:0]  elig;
  logic [1:0]  avail;
  logic [1:0]  own;
  logic [1:0]  other;
  logic [1:0]  split_set;
  logic [1:0]  fld;
  logic [15:0] haddr;
  logic        own_req;
  logic        oth_elig;
  logic        split;
  logic        arb;
  logic        dec_err;
  logic [31:0] rdata;
  logic [1:0]  resp;

  assign req      = {bus.HREQ_2, bus.HREQ_1};
  assign elig     = req & ~mask;
  assign own      = {state == OWN_M2, state == OWN_M1};
  assign other    = {own[0], own[1]};
  assign own_req  = |(own & req);
  assign oth_elig = |(other & elig);

  // dp_mas is one-hot in mask bit order, so it doubles as the split mask set
  assign split = bus.HREADY && dp_slv == 2'd1 && !dp_err
              && bus.HRESP_1 == 2'b11;
  assign split_set = split ? dp_mas : 2'b00;
  assign avail     = elig & ~split_set;

  assign arb = bus.HREADY && (state == IDLE || !own_req
            || (!mlock && hold == HOLD_LIM && oth_elig)
            || |(own & split_set));

  always_comb begin
    win = IDLE;
    unique case (1'b1)
      avail == 2'b11: win = last_m2 ? OWN_M1 : OWN_M2;
      avail == 2'b01: win = OWN_M1;
      avail == 2'b10: win = OWN_M2;
      default:        win = IDLE;
    endcase
  end

  assign haddr   = own[0] ? bus.HADDR_1
                 : own[1] ? bus.HADDR_2 : 16'h0;
  assign fld     = haddr[SLV_LSB+1:SLV_LSB];
  assign dec_err = |own && fld == 2'b00;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      mlock   <= 1'b0;
      last_m2 <= 1'b1;
      mask    <= 2'b00;
      hold    <= 8'd0;
      dp_slv  <= 2'd0;
      dp_mas  <= 2'b00;
      dp_err  <= 1'b0;
    end else begin
      mask <= (mask & ~bus.HSPLIT) | split_set;
      if (bus.HREADY) begin
        dp_slv <= fld;
        dp_mas <= own;
        dp_err <= dec_err;
      end
      if (arb) begin
        state <= win;
        hold  <= 8'd0;
        mlock <= (win == OWN_M1 && bus.HLOCK_1)
              || (win == OWN_M2 && bus.HLOCK_2);
        if (win != IDLE)
          last_m2 <= (win == OWN_M2);
      end else if (!mlock && oth_elig && hold != HOLD_LIM) begin
        hold <= hold + 8'd1;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    resp  = 2'b00;
    if (dp_err) begin
      resp = 2'b01;
    end else begin
      unique case (dp_slv)
        2'd1: begin rdata = bus.HRDATA_1; resp = bus.HRESP_1; end
        2'd2: begin rdata = bus.HRDATA_2; resp = bus.HRESP_2; end
        2'd3: begin rdata = bus.HRDATA_3; resp = bus.HRESP_3; end
        default: ;
      endcase
    end
  end

  assign bus.HGRANT_1 = own[0];
  assign bus.HGRANT_2 = own[1];
  assign bus.HMAS     = own;
  assign bus.MLOCK    = mlock;
  assign bus.SEL_1    = fld == 2'b01;
  assign bus.SEL_2    = fld == 2'b10;
  assign bus.SEL_3    = fld == 2'b11;
  assign bus.HADDR    = haddr;
  assign bus.HWDATA   = dp_mas[0] ? bus.HWDATA_1
                      : dp_mas[1] ? bus.HWDATA_2 : 32'h0;
  assign bus.HRDATA   = rdata;
  assign bus.HRESP    = resp;

endmodule

// File: tb/tb_split_bus_arbiter.sv
// Bench for split_bus_arbiter: directed scenarios plus random traffic
// compared every cycle against an owner/mask level reference model.
module tb_split_bus_arbiter;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  split_bus_arbiter_if bus();

  split_bus_arbiter #(.MAX_HOLD(MH), .SLV_LSB(12)) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // model: owner/last are master numbers 1/2 (0 = nobody)
  int       m_own;
  int       m_last;
  int       m_cnt;
  bit       m_lock;
  bit [2:1] m_mask;
  int       dp_own;
  int       dp_slv;
  bit       dp_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_own  = 0;
    m_last = 2;
    m_cnt  = 0;
    m_lock = 1'b0;
    m_mask = '0;
    dp_own = 0;
    dp_slv = 0;
    dp_err = 1'b0;
  endfunction

  function automatic logic [15:0] own_addr(int who);
    if (who == 1) return bus.HADDR_1;
    if (who == 2) return bus.HADDR_2;
    return 16'h0;
  endfunction

  always @(posedge clk) begin : model_step
    bit   e [1:2];
    bit   a [1:2];
    int   sw, win, oth, f, nmask1, nmask2;
    bit   req_own, arb, oth_e;
    logic [15:0] ad;
    if (rst_n) begin
      e[1] = bus.HREQ_1 && !m_mask[1];
      e[2] = bus.HREQ_2 && !m_mask[2];
      sw = 0;
      if (bus.HREADY && dp_own != 0 && !dp_err && dp_slv == 1
          && bus.HRESP_1 == 2'b11)
        sw = dp_own;
      oth     = (m_own == 1) ? 2 : 1;
      oth_e   = (m_own != 0) && e[oth];
      req_own = (m_own == 1) ? bus.HREQ_1
              : (m_own == 2) ? bus.HREQ_2 : 1'b0;
      arb = bus.HREADY && (m_own == 0 || !req_own
            || (!m_lock && m_cnt == MH - 1 && oth_e)
            || (sw != 0 && sw == m_own));
      a[1] = e[1] && sw != 1;
      a[2] = e[2] && sw != 2;
      if (a[1] && a[2]) win = (m_last == 1) ? 2 : 1;
      else if (a[1])    win = 1;
      else if (a[2])    win = 2;
      else              win = 0;
      nmask1 = (sw == 1) ? 1 : bus.HSPLIT[0] ? 0 : int'(m_mask[1]);
      nmask2 = (sw == 2) ? 1 : bus.HSPLIT[1] ? 0 : int'(m_mask[2]);
      if (bus.HREADY) begin
        ad     = own_addr(m_own);
        f      = int'(ad[13:12]);
        dp_own = m_own;
        dp_slv = (m_own != 0) ? f : 0;
        dp_err = (m_own != 0) && f == 0;
      end
      if (arb) begin
        m_cnt  = 0;
        m_own  = win;
        m_lock = (win == 1) ? bus.HLOCK_1
               : (win == 2) ? bus.HLOCK_2 : 1'b0;
        if (win != 0) m_last = win;
      end else if (m_own != 0 && !m_lock && oth_e && m_cnt < MH - 1) begin
        m_cnt++;
      end
      m_mask[1] = nmask1[0];
      m_mask[2] = nmask2[0];
    end
  end

  always @(negedge clk) begin : compare
    logic [15:0] ea;
    logic [31:0] erd, ewd;
    logic [1:0]  ers, ef;
    ea = own_addr(m_own);
    ef = (m_own != 0) ? ea[13:12] : 2'b00;
    ewd = (dp_own == 1) ? bus.HWDATA_1
        : (dp_own == 2) ? bus.HWDATA_2 : 32'h0;
    erd = 32'h0;
    ers = 2'b00;
    if (dp_err) ers = 2'b01;
    else if (dp_slv == 1) begin erd = bus.HRDATA_1; ers = bus.HRESP_1; end
    else if (dp_slv == 2) begin erd = bus.HRDATA_2; ers = bus.HRESP_2; end
    else if (dp_slv == 3) begin erd = bus.HRDATA_3; ers = bus.HRESP_3; end
    chk("hgrant1", bus.HGRANT_1, m_own == 1);
    chk("hgrant2", bus.HGRANT_2, m_own == 2);
    chk("hmas",    bus.HMAS, (m_own == 1) ? 2'b01 : (m_own == 2) ? 2'b10 : 2'b00);
    chk("mlock",   bus.MLOCK, m_lock);
    chk("sel",     {bus.SEL_3, bus.SEL_2, bus.SEL_1},
                   {ef == 2'b11, ef == 2'b10, ef == 2'b01});
    chk("haddr",   bus.HADDR, ea);
    chk("hwdata",  bus.HWDATA, ewd);
    chk("hrdata",  bus.HRDATA, erd);
    chk("hresp",   bus.HRESP, ers);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.HREQ_1 = 0;   bus.HREQ_2 = 0;
    bus.HLOCK_1 = 0;  bus.HLOCK_2 = 0;
    bus.HADDR_1 = 0;  bus.HADDR_2 = 0;
    bus.HWDATA_1 = 0; bus.HWDATA_2 = 0;
    bus.HRDATA_1 = 0; bus.HRDATA_2 = 0; bus.HRDATA_3 = 0;
    bus.HRESP_1 = 0;  bus.HRESP_2 = 0;  bus.HRESP_3 = 0;
    bus.HREADY = 1;   bus.HSPLIT = 0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) tick();
    chk("rst_grant", {bus.HGRANT_2, bus.HGRANT_1}, 2'b00);
    chk("rst_hresp", bus.HRESP, 2'b00);

    // both request at once: M1 wins the first tie
    rst_n = 1'b1;
    bus.HREQ_1 = 1; bus.HREQ_2 = 1;
    bus.HADDR_1 = 16'h1000; bus.HADDR_2 = 16'h2000;
    bus.HWDATA_1 = 32'hCAFE0001; bus.HWDATA_2 = 32'hCAFE0002;
    tick();
    chk("first_g1", bus.HGRANT_1, 1'b1);
    chk("first_hmas", bus.HMAS, 2'b01);

    // hold limit: M1 keeps grant for exactly MH cycles
    repeat (MH - 1) tick();
    chk("hold_keep", bus.HGRANT_1, 1'b1);
    tick();
    chk("hold_g2", bus.HGRANT_2, 1'b1);
    chk("hold_hmas", bus.HMAS, 2'b10);

    // locked M1 is never pre-empted
    bus.HLOCK_1 = 1;
    repeat (MH) tick();
    chk("lock_g1", bus.HGRANT_1, 1'b1);
    chk("lock_ml", bus.MLOCK, 1'b1);
    repeat (40) tick();
    chk("lock_hold_g1", bus.HGRANT_1, 1'b1);
    chk("lock_hold_ml", bus.MLOCK, 1'b1);
    chk("lock_hold_g2", bus.HGRANT_2, 1'b0);
    bus.HREQ_1 = 0; bus.HLOCK_1 = 0;
    tick();
    chk("unlock_g2", bus.HGRANT_2, 1'b1);
    chk("unlock_ml", bus.MLOCK, 1'b0);

    // decode error on slave field 00
    bus.HRDATA_1 = 32'h11111111;
    bus.HRDATA_2 = 32'h22222222;
    bus.HRDATA_3 = 32'h33333333;
    bus.HADDR_2 = 16'h0ABC;
    #1;
    chk("dec_sel", {bus.SEL_3, bus.SEL_2, bus.SEL_1}, 3'b000);
    tick();
    chk("dec_hresp", bus.HRESP, 2'b01);
    chk("dec_hrdata", bus.HRDATA, 32'h0);

    // split from slave 1 parks M2 until released
    bus.HADDR_2 = 16'h1004;
    tick();
    chk("sp_hwdata", bus.HWDATA, 32'hCAFE0002);
    bus.HRESP_1 = 2'b11;
    #1;
    chk("sp_hresp", bus.HRESP, 2'b11);
    tick();
    bus.HRESP_1 = 2'b00;
    chk("sp_hmas", bus.HMAS, 2'b00);
    bus.HSPLIT = 2'b10;
    tick();
    bus.HSPLIT = 2'b00;
    tick();
    chk("sp_regrant", bus.HGRANT_2, 1'b1);

    // split again with M1 waiting, then reset while M2 is parked
    bus.HREQ_1 = 1;
    bus.HADDR_1 = 16'h3008;
    tick();
    bus.HRESP_1 = 2'b11;
    tick();
    bus.HRESP_1 = 2'b00;
    chk("sp2_hmas", bus.HMAS, 2'b01);
    tick();
    chk("sp2_hrdata", bus.HRDATA, 32'h33333333);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_hmas", bus.HMAS, 2'b00);
    chk("arst_haddr", bus.HADDR, 16'h0);
    chk("arst_hrdata", bus.HRDATA, 32'h0);
    chk("arst_hwdata", bus.HWDATA, 32'h0);
    tick();
    rst_n = 1'b1;
    bus.HREQ_1 = 0;
    tick();
    chk("arst_g2", bus.HGRANT_2, 1'b1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) bus.HREQ_1 = ~bus.HREQ_1;
      if ($urandom_range(0, 7) == 0) bus.HREQ_2 = ~bus.HREQ_2;
      if ($urandom_range(0, 5) == 0) bus.HLOCK_1 = ~bus.HLOCK_1;
      if ($urandom_range(0, 5) == 0) bus.HLOCK_2 = ~bus.HLOCK_2;
      bus.HADDR_1  = 16'($urandom);
      bus.HADDR_2  = 16'($urandom);
      bus.HWDATA_1 = $urandom;
      bus.HWDATA_2 = $urandom;
      bus.HRDATA_1 = $urandom;
      bus.HRDATA_2 = $urandom;
      bus.HRDATA_3 = $urandom;
      bus.HRESP_1  = ($urandom_range(0, 3) == 0) ? 2'b11
                   : 2'($urandom_range(0, 2));
      bus.HRESP_2  = 2'($urandom_range(0, 3));
      bus.HRESP_3  = 2'($urandom_range(0, 3));
      bus.HREADY   = $urandom_range(0, 3) != 0;
      bus.HSPLIT   = {$urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0};
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
